// File: rtl/clkdiv_pkg.sv
// Shared constants, channel state type and ratio helpers for the programmable clock divider.
package clkdiv_pkg;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned DIV_RST_DEF = 1024;

  typedef enum logic {
    IDLE,
    RUN
  } ch_state_e;

  // Ratios below 2 cannot produce both a high and a low phase, so they are raised to 2.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'd2) ? 32'd2 : d;
  endfunction

  // High-phase length: ceil(D/2), so odd ratios get the longer high phase.
  function automatic logic [31:0] high_len(input logic [31:0] d);
    return (d + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: period counter, pending/active ratio, IDLE/RUN control, registered outputs.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             oe_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             load_i,
  input  logic             sync_i,
  output logic             dclk_o,
  output logic             tick_o,
  output logic             upd_pend_o
);

  ch_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [CNT_W-1:0] d_act, d_act_n;
  logic [CNT_W-1:0] d_pend, d_pend_n;
  logic             pend, pend_n;
  logic             dclk, dclk_n;
  logic             tick, tick_n;
  logic             at_bnd;
  logic             restart;

  assign cnt_inc = cnt + CNT_W'(1);
  assign at_bnd  = (state == RUN) && (cnt == d_act - CNT_W'(1));

  // Next-state: period restart on enable/boundary/sync, ratio hand-over, load capture.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    d_act_n  = d_act;
    d_pend_n = d_pend;
    pend_n   = pend;
    dclk_n   = dclk;
    tick_n   = 1'b0;
    restart  = 1'b0;

    case (state)
      IDLE: begin
        cnt_n  = '0;
        dclk_n = 1'b0;
        if (oe_i) begin
          state_n = RUN;
          restart = 1'b1;
        end
      end
      RUN: begin
        if (at_bnd) begin
          if (oe_i) begin
            restart = 1'b1;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
            dclk_n  = 1'b0;
          end
        end else if (sync_i) begin
          restart = 1'b1;
        end else begin
          cnt_n  = cnt_inc;
          dclk_n = (32'(cnt_inc) < high_len(32'(d_act)));
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        dclk_n  = 1'b0;
      end
    endcase

    if (restart) begin
      cnt_n  = '0;
      dclk_n = 1'b1;
      tick_n = 1'b1;
      if (pend) begin
        d_act_n = d_pend;
        pend_n  = 1'b0;
      end
    end

    // Capture after the hand-over so a load on a restart edge stays pending for the next one.
    if (load_i) begin
      d_pend_n = CNT_W'(clamp_div(32'(div_i)));
      pend_n   = 1'b1;
    end
  end

  // Channel state and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      cnt    <= '0;
      d_act  <= CNT_W'(DIV_RST);
      d_pend <= CNT_W'(DIV_RST);
      pend   <= 1'b0;
      dclk   <= 1'b0;
      tick   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      d_act  <= d_act_n;
      d_pend <= d_pend_n;
      pend   <= pend_n;
      dclk   <= dclk_n;
      tick   <= tick_n;
    end
  end

  assign dclk_o     = dclk;
  assign tick_o     = tick;
  assign upd_pend_o = pend;

endmodule

// File: rtl/clkdiv_prog.sv
// Multi-channel programmable clock divider: N_CH independent channels sharing a sync restart.
module clkdiv_prog
  import clkdiv_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [N_CH-1:0]       oe_i,
  input  logic [N_CH*CNT_W-1:0] div_i,
  input  logic [N_CH-1:0]       load_i,
  input  logic                  sync_i,
  output logic [N_CH-1:0]       dclk_o,
  output logic [N_CH-1:0]       tick_o,
  output logic [N_CH-1:0]       upd_pend_o
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    clkdiv_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .oe_i       (oe_i[k]),
      .div_i      (div_i[k*CNT_W +: CNT_W]),
      .load_i     (load_i[k]),
      .sync_i     (sync_i),
      .dclk_o     (dclk_o[k]),
      .tick_o     (tick_o[k]),
      .upd_pend_o (upd_pend_o[k])
    );
  end

endmodule
